// File: rtl/l1_line_burst_addr_gen.sv
// Whole-line burst address generator: rebuilds LC-3b word addresses from
// {tag, index, offset} and walks a cache line critical-word-first.
module l1_line_burst_addr_gen #(
    parameter int TAG_SIZE    = 9,
    parameter int INDEX_SIZE  = 3,
    parameter int OFFSET_SIZE = 3
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   req_valid,
    input  logic                   req_write,
    input  logic [TAG_SIZE-1:0]    req_tag,
    input  logic [INDEX_SIZE-1:0]  req_index,
    input  logic [OFFSET_SIZE-1:0] req_offset,
    output logic                   req_ready,
    output logic [15:0]            mem_address,
    output logic                   mem_read,
    output logic                   mem_write,
    input  logic                   mem_resp,
    output logic [OFFSET_SIZE-1:0] word_sel,
    output logic                   busy,
    output logic                   done,
    output logic [1:0]             state_dbg
);

    if (TAG_SIZE + INDEX_SIZE + OFFSET_SIZE + 1 != 16) begin : g_bad_split
        $error("l1_line_burst_addr_gen: tag+index+offset+1 must equal 16");
    end

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    localparam logic [OFFSET_SIZE-1:0] LAST_BEAT = '1;
    localparam logic [OFFSET_SIZE-1:0] OFF_ONE   = OFFSET_SIZE'(1);

    logic [1:0]             state;
    logic [TAG_SIZE-1:0]    tag_q;
    logic [INDEX_SIZE-1:0]  index_q;
    logic [OFFSET_SIZE-1:0] cur_offset;
    logic [OFFSET_SIZE-1:0] beat_cnt;
    logic                   write_q;

    // Request fields are captured only on the accepting edge; the beat
    // counter is separate from cur_offset because the walk starts mid-line.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            tag_q      <= '0;
            index_q    <= '0;
            cur_offset <= '0;
            beat_cnt   <= '0;
            write_q    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        tag_q      <= req_tag;
                        index_q    <= req_index;
                        cur_offset <= req_offset;
                        write_q    <= req_write;
                        beat_cnt   <= '0;
                        state      <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (mem_resp) begin
                        if (beat_cnt == LAST_BEAT) begin
                            state <= ST_DONE;
                        end else begin
                            cur_offset <= cur_offset + OFF_ONE;
                            beat_cnt   <= beat_cnt + OFF_ONE;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Outputs decode straight from state so an asynchronous reset drops the
    // strobes in the same cycle.
    assign req_ready   = (state == ST_IDLE);
    assign busy        = (state == ST_ACCESS);
    assign done        = (state == ST_DONE);
    assign mem_read    = (state == ST_ACCESS) && !write_q;
    assign mem_write   = (state == ST_ACCESS) && write_q;
    assign mem_address = {tag_q, index_q, cur_offset, 1'b0};
    assign word_sel    = cur_offset;
    assign state_dbg   = state;

endmodule

// File: tb/tb_l1_line_burst_addr_gen.sv
// Self-checking bench for l1_line_burst_addr_gen: vector table, directed
// corner sequences and randomized transfers against an arithmetic model.
module tb_l1_line_burst_addr_gen;

    logic        clk;
    logic        reset_n;
    logic        req_valid;
    logic        req_write;
    logic [8:0]  req_tag;
    logic [2:0]  req_index;
    logic [2:0]  req_offset;
    logic        req_ready;
    logic [15:0] mem_address;
    logic        mem_read;
    logic        mem_write;
    logic        mem_resp;
    logic [2:0]  word_sel;
    logic        busy;
    logic        done;
    logic [1:0]  state_dbg;

    int checks = 0;
    int errors = 0;

    l1_line_burst_addr_gen #(
        .TAG_SIZE(9), .INDEX_SIZE(3), .OFFSET_SIZE(3)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_write(req_write),
        .req_tag(req_tag), .req_index(req_index), .req_offset(req_offset),
        .req_ready(req_ready), .mem_address(mem_address),
        .mem_read(mem_read), .mem_write(mem_write), .mem_resp(mem_resp),
        .word_sel(word_sel), .busy(busy), .done(done), .state_dbg(state_dbg)
    );

    // ---------------- clock / watchdog ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- reference model ----------------
    function automatic logic [15:0] model_addr(int tag, int idx, int off);
        return 16'(tag * 128 + idx * 16 + (off % 8) * 2);
    endfunction

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!req_ready && n < 50) begin
            step();
            n++;
        end
        chk("ready_wait", 32'(req_ready), 32'd1);
    endtask

    task automatic chk_idle(input string name);
        chk({name, "_ready"}, 32'(req_ready), 32'd1);
        chk({name, "_strobe"}, {30'd0, mem_write, mem_read}, 32'd0);
        chk({name, "_busy_done"}, {30'd0, busy, done}, 32'd0);
    endtask

    // Runs all 8 beats of a transfer already in ACCESS, finishing in the DONE cycle.
    task automatic run_beats(input int tag, input int idx, input int off, input bit wr,
                             input int glo, input int ghi, input bit resp_in_done,
                             output logic [15:0] first_addr, output logic [15:0] last_addr);
        logic [15:0] exp_q[$];
        int strobe_cycles = 0;
        int exp_cycles = 0;
        int w;
        first_addr = '0;
        last_addr  = '0;
        for (int k = 0; k < 8; k++) exp_q.push_back(model_addr(tag, idx, off + k));
        for (int beat = 0; beat < 8; beat++) begin
            w = int'($urandom_range(ghi, glo));
            exp_cycles += w + 1;
            for (int c = 0; c <= w; c++) begin
                chk("addr", 32'(mem_address), 32'(exp_q[0]));
                chk("word_sel", 32'(word_sel), 32'((off + beat) % 8));
                chk("strobe", {30'd0, mem_write, mem_read}, wr ? 32'd2 : 32'd1);
                chk("access_flags", {29'd0, busy, req_ready, done}, 32'd4);
                if (mem_read || mem_write) strobe_cycles++;
                if (beat == 0 && c == 0) first_addr = mem_address;
                last_addr = mem_address;
                mem_resp = (c == w);
                step();
            end
            void'(exp_q.pop_front());
        end
        mem_resp = resp_in_done;
        chk("strobe_cycles", 32'(strobe_cycles), 32'(exp_cycles));
        chk("done_pulse", 32'(done), 32'd1);
        chk("done_flags", {29'd0, busy, req_ready, mem_read | mem_write}, 32'd0);
    endtask

    task automatic run_txn(input int tag, input int idx, input int off, input bit wr,
                           input int glo, input int ghi, input bit resp_in_done,
                           output logic [15:0] first_addr, output logic [15:0] last_addr);
        wait_ready();
        req_tag    = 9'(tag);
        req_index  = 3'(idx);
        req_offset = 3'(off);
        req_write  = wr;
        req_valid  = 1'b1;
        step();
        // Scramble the request inputs: the transfer must use the latched copy.
        req_valid  = 1'b0;
        req_tag    = 9'($urandom_range(511, 0));
        req_index  = 3'($urandom_range(7, 0));
        req_offset = 3'($urandom_range(7, 0));
        req_write  = 1'($urandom_range(1, 0));
        run_beats(tag, idx, off, wr, glo, ghi, resp_in_done, first_addr, last_addr);
        step();
        mem_resp = 1'b0;
        chk_idle("post_done");
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [8:0]  tag;
        logic [2:0]  idx;
        logic [2:0]  off;
        logic        wr;
        int          glo;
        int          ghi;
        logic [15:0] exp_first;
        logic [15:0] exp_last;
    } vec_t;

    vec_t vecs[4];

    initial begin
        logic [15:0] fa, la;
        logic [2:0]  ws_before;
        int t, ix, of, gh;
        bit wr;

        vecs[0] = '{9'h1A3, 3'd5, 3'd0, 1'b0, 0, 0, 16'hD1D0, 16'hD1DE};
        vecs[1] = '{9'h001, 3'd2, 3'd6, 1'b1, 0, 0, 16'h00AC, 16'h00AA};
        vecs[2] = '{9'h0FF, 3'd7, 3'd3, 1'b0, 2, 2, 16'h7FF6, 16'h7FF4};
        vecs[3] = '{9'h1FF, 3'd0, 3'd7, 1'b1, 1, 1, 16'hFF8E, 16'hFF8C};

        reset_n    = 1'b0;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_tag    = '0;
        req_index  = '0;
        req_offset = '0;
        mem_resp   = 1'b0;
        step();
        step();
        chk_idle("reset");
        chk("reset_addr", 32'(mem_address), 32'd0);
        chk("reset_word_sel", 32'(word_sel), 32'd0);
        reset_n = 1'b1;
        step();
        chk_idle("after_reset");

        // Spurious response in IDLE must not start anything.
        ws_before = word_sel;
        mem_resp = 1'b1;
        step();
        mem_resp = 1'b0;
        chk_idle("idle_spurious");
        chk("idle_spurious_ws", 32'(word_sel), 32'(ws_before));

        // Table vectors; the last one also pulses mem_resp during DONE.
        for (int i = 0; i < 4; i++) begin
            run_txn(vecs[i].tag, vecs[i].idx, vecs[i].off, vecs[i].wr,
                    vecs[i].glo, vecs[i].ghi, (i == 3), fa, la);
            chk($sformatf("vec%0d_first", i), 32'(fa), 32'(vecs[i].exp_first));
            chk($sformatf("vec%0d_last", i), 32'(la), 32'(vecs[i].exp_last));
        end

        // Reset in the middle of a writeback after 3 beats.
        wait_ready();
        req_tag = 9'h0AA; req_index = 3'd1; req_offset = 3'd4; req_write = 1'b1;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        for (int b = 0; b < 3; b++) begin
            chk("rst_mid_strobe", {30'd0, mem_write, mem_read}, 32'd2);
            mem_resp = 1'b1;
            step();
        end
        mem_resp = 1'b0;
        chk("rst_mid_addr", 32'(mem_address), 32'(model_addr(9'h0AA, 1, 4 + 3)));
        reset_n = 1'b0;
        #1;
        chk("rst_mid_strobe_drop", {30'd0, mem_write, mem_read}, 32'd0);
        chk("rst_mid_ready", 32'(req_ready), 32'd1);
        step();
        reset_n = 1'b1;
        step();
        chk_idle("rst_mid_release");
        run_txn(9'h0AA, 1, 1, 1'b0, 0, 1, 1'b0, fa, la);
        chk("rst_restart_first", 32'(fa), 32'(model_addr(9'h0AA, 1, 1)));

        // Back-to-back: second request held valid through ACCESS and DONE.
        wait_ready();
        req_tag = 9'h155; req_index = 3'd3; req_offset = 3'd2; req_write = 1'b0;
        req_valid = 1'b1;
        step();
        req_tag = 9'h0C3; req_index = 3'd6; req_offset = 3'd5; req_write = 1'b1;
        run_beats(9'h155, 3, 2, 1'b0, 0, 0, 1'b0, fa, la);
        step();
        chk_idle("b2b_idle_gap");
        step();
        req_valid = 1'b0;
        run_beats(9'h0C3, 6, 5, 1'b1, 0, 1, 1'b0, fa, la);
        chk("b2b_second_first", 32'(fa), 32'(model_addr(9'h0C3, 6, 5)));
        step();
        chk_idle("b2b_end");

        // Randomized transfers with random per-beat waits.
        for (int n = 0; n < 24; n++) begin
            t  = int'($urandom_range(511, 0));
            ix = int'($urandom_range(7, 0));
            of = int'($urandom_range(7, 0));
            wr = 1'($urandom_range(1, 0));
            gh = int'($urandom_range(3, 0));
            run_txn(t, ix, of, wr, 0, gh, 1'($urandom_range(1, 0)), fa, la);
            chk("rand_first", 32'(fa), 32'(model_addr(t, ix, of)));
            chk("rand_last", 32'(la), 32'(model_addr(t, ix, of + 7)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
